// File: rtl/hazard_ctrl_if.sv
// Decode-stage hazard handshake: decode presents its instruction fields,
// and the hazard controller answers with stall/bubble/halt status.
interface hazard_ctrl_if;
   logic        id_valid;
   logic [15:0] id_instr;
   logic        id_rs_used;
   logic        id_rt_used;
   logic        id_regwrt;
   logic [2:0]  id_rd;
   logic        flush;
   logic        stall;
   logic        bubble;
   logic        halted;
   logic [15:0] stall_cnt;

   modport master (
      output id_valid, id_instr, id_rs_used, id_rt_used, id_regwrt, id_rd, flush,
      input  stall, bubble, halted, stall_cnt
   );

   modport slave (
      input  id_valid, id_instr, id_rs_used, id_rt_used, id_regwrt, id_rd, flush,
      output stall, bubble, halted, stall_cnt
   );
endinterface

// File: rtl/hazard_ctrl.sv
// Decode-stage RAW hazard controller: two-entry destination scoreboard (EX, MEM),
// stall/bubble generation, and HALT drain sequencing.
module hazard_ctrl (
   input  logic      clk,
   input  logic      rst,
   hazard_ctrl_if.slave bus
);

   typedef enum logic [1:0] {RUN, DRAIN, HALTED} state_e;

   typedef struct packed {
      logic       v;
      logic [2:0] rd;
   } sb_entry_t;

   localparam logic [4:0]  OP_HALT  = 5'b00000;
   localparam logic [15:0] CNT_MAX  = 16'hFFFF;

   state_e      state_q, state_d;
   sb_entry_t   s_ex_q, s_ex_d;
   sb_entry_t   s_mem_q, s_mem_d;
   logic        halted_q, halted_d;
   logic [15:0] stall_cnt_q, stall_cnt_d;

   logic [2:0]  rs, rt;
   logic        is_halt;
   logic        hazard;
   logic        stall_run;
   logic        issue;
   logic        unused_instr;

   function automatic logic hit(input sb_entry_t e, input logic [2:0] r);
      return e.v && (e.rd == r);
   endfunction

   assign rs           = bus.id_instr[10:8];
   assign rt           = bus.id_instr[7:5];
   assign is_halt      = (bus.id_instr[15:11] == OP_HALT);
   assign unused_instr = ^bus.id_instr[4:0];

   // WB needs no entry: the register file forwards same-cycle writes to reads.
   assign hazard = bus.id_valid &
                   ((bus.id_rs_used & (hit(s_ex_q, rs) | hit(s_mem_q, rs))) |
                    (bus.id_rt_used & (hit(s_ex_q, rt) | hit(s_mem_q, rt))));

   // Flush beats hazard: the squashed instruction neither stalls nor issues.
   assign stall_run = hazard & ~bus.flush;
   assign issue     = bus.id_valid & ~stall_run & ~bus.flush & (state_q == RUN);

   // NOTE: every output of an always_comb gets a default first so no path
   // leaves a value unassigned and infers a latch.
   always_comb begin
      bus.stall  = 1'b1;
      bus.bubble = 1'b1;
      if (!rst) begin
         bus.stall  = 1'b0;
      end else if (state_q == RUN) begin
         bus.stall  = stall_run;
         bus.bubble = stall_run | bus.flush | ~bus.id_valid;
      end
   end

   assign bus.halted    = halted_q & rst;
   assign bus.stall_cnt = stall_cnt_q;

   always_comb begin
      s_mem_d     = s_ex_q;
      s_ex_d.v    = issue & bus.id_regwrt & ~is_halt;
      s_ex_d.rd   = bus.id_rd;
      state_d     = state_q;
      stall_cnt_d = stall_cnt_q;

      case (state_q)
         RUN: begin
            if (issue && is_halt) state_d = DRAIN;
            if (stall_run && (stall_cnt_q != CNT_MAX)) stall_cnt_d = stall_cnt_q + 16'd1;
         end
         DRAIN: begin
            if (!s_ex_q.v && !s_mem_q.v) state_d = HALTED;
         end
         HALTED:  state_d = HALTED;
         default: state_d = RUN;
      endcase

      halted_d = (state_d == HALTED);
   end

   // NOTE: sequential state uses non-blocking assignments so every flop samples
   // the pre-edge values; reset is synchronous and sampled on the clock edge.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q     <= RUN;
         s_ex_q      <= '0;
         s_mem_q     <= '0;
         halted_q    <= 1'b0;
         stall_cnt_q <= '0;
      end else begin
         state_q     <= state_d;
         s_ex_q      <= s_ex_d;
         s_mem_q     <= s_mem_d;
         halted_q    <= halted_d;
         stall_cnt_q <= stall_cnt_d;
      end
   end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed scoreboard bench for hazard_ctrl: each stimulus cycle pushes its
// hand-computed expected outputs, and a monitor compares them at the falling edge.
module tb_hazard_ctrl;

   typedef struct {
      logic        stall;
      logic        bubble;
      logic        halted;
      logic [15:0] cnt;
   } exp_t;

   logic clk;
   logic rst;
   hazard_ctrl_if bus ();

   hazard_ctrl dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   exp_t exp_q[$];
   int   checks = 0;
   int   errors = 0;
   int   cyc_no = 0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s cycle %0d: got %h expected %h", name, cyc_no, act, exp);
      end
   endtask

   // One pipeline cycle: drive inputs just after the rising edge, queue expectations.
   task automatic cyc(input logic r, input logic v, input logic [4:0] op,
                      input logic [2:0] rs, input logic [2:0] rt,
                      input logic ru, input logic tu, input logic w,
                      input logic [2:0] rd, input logic fl,
                      input logic es, input logic eb, input logic eh,
                      input logic [15:0] ec);
      exp_t e;
      @(posedge clk);
      #1;
      rst            = r;
      bus.id_valid   = v;
      bus.id_instr   = {op, rs, rt, 5'b00000};
      bus.id_rs_used = ru;
      bus.id_rt_used = tu;
      bus.id_regwrt  = w;
      bus.id_rd      = rd;
      bus.flush      = fl;
      e.stall  = es;
      e.bubble = eb;
      e.halted = eh;
      e.cnt    = ec;
      exp_q.push_back(e);
   endtask

   initial begin : monitor
      exp_t e;
      forever begin
         @(negedge clk);
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            cyc_no++;
            check("stall",     {15'd0, bus.stall},  {15'd0, e.stall});
            check("bubble",    {15'd0, bus.bubble}, {15'd0, e.bubble});
            check("halted",    {15'd0, bus.halted}, {15'd0, e.halted});
            check("stall_cnt", bus.stall_cnt,       e.cnt);
         end
      end
   end

   initial begin : watchdog
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin : stimulus
      rst            = 1'b0;
      bus.id_valid   = 1'b0;
      bus.id_instr   = '0;
      bus.id_rs_used = 1'b0;
      bus.id_rt_used = 1'b0;
      bus.id_regwrt  = 1'b0;
      bus.id_rd      = '0;
      bus.flush      = 1'b0;
      repeat (2) @(posedge clk);

      // Reset: outputs forced, counter cleared
      cyc(0,1,1,3,3,1,1,1,3,0, 0,1,0,16'd0);
      cyc(0,1,1,3,3,1,1,1,3,0, 0,1,0,16'd0);

      // ADD r3 then SUB reading r3: two stalls, then issue
      cyc(1,1,1,1,2,1,1,1,3,0, 0,0,0,16'd0);
      cyc(1,1,1,3,5,1,1,1,4,0, 1,1,0,16'd0);
      cyc(1,1,1,3,5,1,1,1,4,0, 1,1,0,16'd1);
      cyc(1,1,1,3,5,1,1,1,4,0, 0,0,0,16'd2);

      // Producer r3, independent, consumer on rt=3: one stall
      cyc(1,1,1,1,2,1,1,1,3,0, 0,0,0,16'd2);
      cyc(1,1,1,6,7,1,1,1,6,0, 0,0,0,16'd2);
      cyc(1,1,1,1,3,1,1,1,5,0, 1,1,0,16'd2);
      cyc(1,1,1,1,3,1,1,1,5,0, 0,0,0,16'd3);
      // Producer r3 then rt=3 with rt unused: no stall
      cyc(1,1,1,1,2,1,1,1,3,0, 0,0,0,16'd3);
      cyc(1,1,1,1,3,1,0,0,0,0, 0,0,0,16'd3);

      // Flush in hazard cycle, then a new consumer sees only the MEM entry
      cyc(1,1,1,1,2,1,0,1,3,0, 0,0,0,16'd3);
      cyc(1,1,1,3,0,1,0,1,7,1, 0,1,0,16'd3);
      cyc(1,1,1,3,0,1,0,1,7,0, 1,1,0,16'd3);
      cyc(1,1,1,3,0,1,0,1,7,0, 0,0,0,16'd4);

      // Store-type (no write) then consumer: no stall; invalid slot never stalls
      cyc(1,1,1,1,2,1,1,0,3,0, 0,0,0,16'd4);
      cyc(1,1,1,3,3,1,1,0,0,0, 0,0,0,16'd4);
      cyc(1,1,1,1,0,1,0,1,2,0, 0,0,0,16'd4);
      cyc(1,0,1,2,0,1,0,1,4,0, 0,1,0,16'd4);
      cyc(1,0,1,0,0,0,0,0,0,0, 0,1,0,16'd4);

      // Both sources hazarding on different entries: max of the two
      cyc(1,1,1,5,0,1,0,1,1,0, 0,0,0,16'd4);
      cyc(1,1,1,6,0,1,0,1,2,0, 0,0,0,16'd4);
      cyc(1,1,1,1,2,1,1,1,3,0, 1,1,0,16'd4);
      cyc(1,1,1,1,2,1,1,1,3,0, 1,1,0,16'd5);
      cyc(1,1,1,1,2,1,1,1,3,0, 0,0,0,16'd6);

      // r0 is an ordinary register
      cyc(1,1,1,5,0,1,0,1,0,0, 0,0,0,16'd6);
      cyc(1,1,1,0,0,1,0,0,0,0, 1,1,0,16'd6);
      cyc(1,1,1,0,0,1,0,0,0,0, 1,1,0,16'd7);
      cyc(1,1,1,0,0,1,0,0,0,0, 0,0,0,16'd8);

      // Preload the counter near saturation between edges
      @(negedge clk);
      #1;
      force dut.stall_cnt_q = 16'hFFFE;
      #1;
      release dut.stall_cnt_q;

      cyc(1,1,1,1,0,1,0,1,3,0, 0,0,0,16'hFFFE);
      cyc(1,1,1,3,0,1,0,1,4,0, 1,1,0,16'hFFFE);
      cyc(1,1,1,3,0,1,0,1,4,0, 1,1,0,16'hFFFF);
      cyc(1,1,1,3,0,1,0,1,4,0, 0,0,0,16'hFFFF);
      cyc(1,1,1,4,0,1,0,1,5,0, 1,1,0,16'hFFFF);
      cyc(1,1,1,4,0,1,0,1,5,0, 1,1,0,16'hFFFF);
      cyc(1,1,1,4,0,1,0,1,5,0, 0,0,0,16'hFFFF);

      // Writer r2, gap, HALT: one DRAIN cycle, then HALTED ignores inputs and flush
      cyc(1,1,1,1,0,1,0,1,2,0, 0,0,0,16'hFFFF);
      cyc(1,0,1,0,0,0,0,0,0,0, 0,1,0,16'hFFFF);
      cyc(1,1,0,0,0,0,0,0,0,0, 0,0,0,16'hFFFF);
      cyc(1,1,1,1,0,1,0,1,3,0, 1,1,0,16'hFFFF);
      cyc(1,1,1,1,0,1,0,1,3,1, 1,1,1,16'hFFFF);
      cyc(1,0,1,0,0,0,0,0,0,0, 1,1,1,16'hFFFF);
      cyc(0,1,1,1,0,1,0,1,3,0, 0,1,0,16'hFFFF);
      cyc(0,1,1,1,0,1,0,1,3,0, 0,1,0,16'd0);

      // Writer immediately before HALT: DRAIN waits for the MEM entry
      cyc(1,1,1,1,0,1,0,1,2,0, 0,0,0,16'd0);
      cyc(1,1,0,0,0,0,0,0,0,0, 0,0,0,16'd0);
      cyc(1,1,1,2,0,1,0,1,3,0, 1,1,0,16'd0);
      cyc(1,1,1,2,0,1,0,1,3,0, 1,1,0,16'd0);
      cyc(1,1,1,2,0,1,0,1,3,0, 1,1,1,16'd0);
      cyc(0,0,1,0,0,0,0,0,0,0, 0,1,0,16'd0);

      // Reset during DRAIN clears the scoreboard and returns to RUN
      cyc(1,1,1,1,0,1,0,1,2,0, 0,0,0,16'd0);
      cyc(1,1,0,0,0,0,0,0,0,0, 0,0,0,16'd0);
      cyc(0,1,1,2,0,1,0,1,3,0, 0,1,0,16'd0);
      cyc(1,1,1,2,0,1,0,1,3,0, 0,0,0,16'd0);
      cyc(1,1,1,3,0,1,0,1,4,0, 1,1,0,16'd0);
      cyc(1,1,1,3,0,1,0,1,4,0, 1,1,0,16'd1);
      cyc(1,1,1,3,0,1,0,1,4,0, 0,0,0,16'd2);

      repeat (3) @(negedge clk);
      #1;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
